// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: handshake state constants and per-stage payload layouts with their nop encodings.
`ifndef nop_PC
`define nop_PC     32'h0000_0000
`endif
`ifndef nop_nPC
`define nop_nPC    32'h0000_0004
`endif
`ifndef nop_COMMIT
`define nop_COMMIT 1'b0
`endif
`ifndef nop_INSTR
`define nop_INSTR  32'h0000_0013
`endif

package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_TWO   = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        commit;
        logic [31:0] instr;
    } de_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        commit;
        logic [31:0] instr;
        logic [31:0] alu;
    } em_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        commit;
        logic [31:0] instr;
        logic [31:0] wdata;
    } mw_payload_t;

    localparam de_payload_t DE_NOP = '{pc: `nop_PC, npc: `nop_nPC, commit: `nop_COMMIT,
                                       instr: `nop_INSTR};
    localparam em_payload_t EM_NOP = '{pc: `nop_PC, npc: `nop_nPC, commit: `nop_COMMIT,
                                       instr: `nop_INSTR, alu: 32'h0};
    localparam mw_payload_t MW_NOP = '{pc: `nop_PC, commit: `nop_COMMIT, instr: `nop_INSTR,
                                       wdata: 32'h0};

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter for stage statistics; holds at all-ones, cleared only by reset.
module pipe_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst)
            r_cnt <= '0;
        else if (inc_i && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to add saturating stall/flush counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_DATA = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
`ifdef PIPE_STAGE_STATS_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
`endif
    output logic [1:0]        occ_o
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_stage_skid: DATA_W and CNT_W must be >= 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_acc;
    logic              w_con;

    assign w_acc = s_valid_i & s_ready_o;
    assign w_con = m_valid_o & m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_EMPTY;
        if (!flush_i) begin
            case (r_state)
                ST_EMPTY: w_state_nxt = w_acc ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (w_acc && !w_con)
                        w_state_nxt = ST_TWO;
                    else if (!w_acc && w_con)
                        w_state_nxt = ST_EMPTY;
                    else
                        w_state_nxt = ST_ONE;
                end
                ST_TWO:   w_state_nxt = w_con ? ST_ONE : ST_TWO;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Payload moves are keyed off the same state/handshake decode as the FSM.
    always_comb begin
        w_main_nxt = NOP_DATA;
        w_skid_nxt = NOP_DATA;
        if (!flush_i) begin
            case (r_state)
                ST_EMPTY: w_main_nxt = w_acc ? s_data_i : r_main;
                ST_ONE: begin
                    w_main_nxt = r_main;
                    w_skid_nxt = r_skid;
                    if (w_acc && w_con)
                        w_main_nxt = s_data_i;
                    else if (w_acc)
                        w_skid_nxt = s_data_i;
                    else if (w_con)
                        w_main_nxt = NOP_DATA;
                end
                ST_TWO: begin
                    w_main_nxt = w_con ? r_skid : r_main;
                    w_skid_nxt = w_con ? NOP_DATA : r_skid;
                end
                default: begin
                    w_main_nxt = NOP_DATA;
                    w_skid_nxt = NOP_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_main <= NOP_DATA;
            r_skid <= NOP_DATA;
        end else begin
            r_main <= w_main_nxt;
            r_skid <= w_skid_nxt;
        end
    end

    // Outputs decode the state register only, so no input reaches an output combinationally.
    always_comb begin
        m_valid_o = (r_state != ST_EMPTY);
        s_ready_o = (r_state != ST_TWO);
        occ_o     = r_state;
        m_data_o  = r_main;
    end

`ifdef PIPE_STAGE_STATS_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = m_valid_o & ~m_ready_i;
    assign w_flush_inc = flush_i & (occ_o != 2'd0);

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst   (rst),
        .inc_i (w_stall_inc),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst   (rst),
        .inc_i (w_flush_inc),
        .cnt_o (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int          DW  = 32;
    localparam logic [31:0] NOP = 32'h13;
    localparam int          CW  = 3;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    occ;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .NOP_DATA(NOP), .CNT_W(CW)) dut (
        .clk_i     (clk),
        .rst       (rst),
        .flush_i   (flush),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
`endif
        .occ_o     (occ)
    );

    logic [DW-1:0] q[$];
    int stall_m = 0;
    int flush_m = 0;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("m_valid", {31'd0, m_valid}, {31'd0, sz > 0});
        chk("s_ready", {31'd0, s_ready}, {31'd0, sz < 2});
        chk("occ",     {30'd0, occ},     sz);
        chk("m_data",  m_data,           (sz > 0) ? q[0] : NOP);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt", {29'd0, stall_cnt}, stall_m);
        chk("flush_cnt", {29'd0, flush_cnt}, flush_m);
`endif
    endtask

    // One clock: drive, let the DUT take the edge, advance the model, check mid-cycle.
    task automatic step(input logic r, input logic f, input logic sv, input logic [DW-1:0] sd,
                        input logic mr);
        bit v, rd;
        rst = r; flush = f; s_valid = sv; s_data = sd; m_ready = mr;
        v  = (q.size() > 0);
        rd = (q.size() < 2);
        @(posedge clk);
        if (r) begin
            q.delete();
            stall_m = 0;
            flush_m = 0;
        end else begin
            if (v && !mr && stall_m < CMAX) stall_m++;
            if (f && q.size() != 0 && flush_m < CMAX) flush_m++;
            if (f) q.delete();
            else begin
                if (v && mr) void'(q.pop_front());
                if (sv && rd) q.push_back(sd);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'hdead, 1);
        chk("rst_data", m_data, 32'h13);
        chk("rst_occ", {30'd0, occ}, 0);

        // streaming
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, i, 1);
            chk("stream_data", m_data, i);
        end
        step(0, 0, 0, 0, 1);

        // backpressure
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        chk("bp_occ2", {30'd0, occ}, 2);
        chk("bp_ready", {31'd0, s_ready}, 0);
        step(0, 0, 1, 32'hC, 0);
        step(0, 0, 1, 32'hC, 1);
        chk("bp_out_b", m_data, 32'hB);
        step(0, 0, 1, 32'hC, 1);
        chk("bp_out_c", m_data, 32'hC);
        step(0, 0, 0, 0, 1);
        chk("bp_empty", {31'd0, m_valid}, 0);

        // flush at occ 2 with concurrent input
        step(0, 0, 1, 32'h1, 0);
        step(0, 0, 1, 32'h2, 0);
        step(0, 1, 1, 32'h77, 1);
        chk("flush_occ", {30'd0, occ}, 0);
        chk("flush_data", m_data, NOP);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_cnt1", {29'd0, flush_cnt}, 1);
`endif

        // drain
        step(0, 0, 1, 32'h55, 0);
        step(0, 0, 0, 0, 1);
        chk("drain_valid", {31'd0, m_valid}, 0);
        chk("drain_data", m_data, NOP);

        // stall saturation
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 32'h99, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_sat", {29'd0, stall_cnt}, 7);
        step(0, 0, 0, 0, 0);
        chk("stall_hold", {29'd0, stall_cnt}, 7);
`endif
        chk("stall_data", m_data, 32'h99);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
